sc_fir_stream: RTL and testbench

Parametrised stochastic-computing FIR engine: next generation of the HWA filter, running entirely on the digital clock. Each accepted input sample shifts into a TAPS-deep delay line. Every tap value and its loadable coefficient are converted to deterministic unipolar bitstreams of length 2^LOG_LEN. The AND-products of those streams are popcount-accumulated, and one scaled N-bit result is emitted per sample with a valid pulse. A ready/valid input handshake and a single clock replace the separate sampling clock.

---
 rtl/sc_fir_stream.sv | 138 +++++++++++++
 tb/tb_sc_fir_stream.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_fir_stream.sv
// sc_fir_stream: stochastic-computing FIR engine with a ready/valid sample port.
// Tap and coefficient streams are ANDed and popcount-accumulated over 2^LOG_LEN cycles.
module sc_fir_stream #(
    parameter int N       = 12,
    parameter int TAPS    = 18,
    parameter int LOG_LEN = 12
) (
    input  logic                    clock_d,
    input  logic                    reset_n,
    input  logic [N-1:0]            in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [N-1:0]            coef_data,
    output logic [N-1:0]            out,
    output logic                    done
);
    localparam int CW = $clog2(TAPS);
    localparam int PW = $clog2(TAPS + 1);
    localparam int AW = PW + LOG_LEN;
    localparam int SH = N - LOG_LEN;
    localparam int WW = AW + SH;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nxt;

    logic [N-1:0]       x    [TAPS];
    logic [N-1:0]       coef [TAPS];
    logic [LOG_LEN-1:0] cnt;
    logic [LOG_LEN-1:0] r2;
    logic [AW-1:0]      acc;
    logic [AW-1:0]      acc_sum;
    logic [TAPS-1:0]    p;
    logic [PW-1:0]      pc;
    logic [WW-1:0]      wide;
    logic [N-1:0]       res;
    logic               hs;
    logic               last;
    logic               cw_ok;

    always_ff @(posedge clock_d or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        hs        = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                hs       = in_valid;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                last = (cnt == '1);
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Second comparator threshold is the bit-reversed count, decorrelating the two streams.
    always_comb begin
        r2 = '0;
        for (int i = 0; i < LOG_LEN; i++) begin
            r2[i] = cnt[LOG_LEN-1-i];
        end
    end

    always_comb begin
        p = '0;
        for (int k = 0; k < TAPS; k++) begin
            p[k] = (x[k][N-1 -: LOG_LEN] > cnt) &
                   (coef[k][N-1 -: LOG_LEN] > r2);
        end
    end

    always_comb begin
        pc = '0;
        for (int k = 0; k < TAPS; k++) begin
            pc = pc + PW'(p[k]);
        end
    end

    assign acc_sum = acc + AW'(pc);
    assign wide    = (WW'(acc_sum) << SH) >> CW;
    assign res     = (|wide[WW-1:N]) ? '1 : wide[N-1:0];

    assign cw_ok = coef_we && (state == IDLE) && (int'(coef_addr) < TAPS);

    always_ff @(posedge clock_d or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x[k]    <= '0;
                coef[k] <= '0;
            end
            cnt  <= '0;
            acc  <= '0;
            out  <= '0;
            done <= 1'b0;
        end else begin
            done <= last;
            if (cw_ok) begin
                coef[coef_addr] <= coef_data;
            end
            if (hs) begin
                x[0] <= in;
                for (int k = 1; k < TAPS; k++) begin
                    x[k] <= x[k-1];
                end
                cnt <= '0;
                acc <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                acc <= acc_sum;
            end
            if (last) begin
                out <= res;
            end
        end
    end

endmodule

// File: tb/tb_sc_fir_stream.sv
// tb_sc_fir_stream: scoreboard bench for sc_fir_stream.
// Directed test-plan cases plus random samples checked against a counting model.
module tb_sc_fir_stream;
    localparam int N       = 12;
    localparam int TAPS    = 18;
    localparam int LOG_LEN = 12;
    localparam int L       = 1 << LOG_LEN;
    localparam int AB      = $clog2(TAPS);

    logic          clock_d   = 1'b0;
    logic          reset_n   = 1'b0;
    logic [N-1:0]  in        = '0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic          coef_we   = 1'b0;
    logic [AB-1:0] coef_addr = '0;
    logic [N-1:0]  coef_data = '0;
    logic [N-1:0]  out;
    logic          done;

    sc_fir_stream #(
        .N      (N),
        .TAPS   (TAPS),
        .LOG_LEN(LOG_LEN)
    ) dut (
        .clock_d  (clock_d),
        .reset_n  (reset_n),
        .in       (in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .out      (out),
        .done     (done)
    );

    always #5 clock_d = ~clock_d;

    int total = 0;
    int bad   = 0;
    int edges = 0;
    int exp_q[$];
    int hs_q[$];
    int xm[TAPS];
    int cm[TAPS];
    int last_hs;

    always @(posedge clock_d) edges <= edges + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, req);
        end
    endtask

    function automatic int bitrev(input int c);
        int r = 0;
        for (int i = 0; i < LOG_LEN; i++) begin
            if (c[i]) r |= 1 << (LOG_LEN - 1 - i);
        end
        return r;
    endfunction

    // Count, per tap, the stream positions where both unipolar streams are 1.
    function automatic int model();
        longint s = 0;
        for (int k = 0; k < TAPS; k++) begin
            int xv = xm[k] >> (N - LOG_LEN);
            int cv = cm[k] >> (N - LOG_LEN);
            for (int c = 0; c < L; c++) begin
                if (c < xv && bitrev(c) < cv) s++;
            end
        end
        s = (s << (N - LOG_LEN)) >> $clog2(TAPS);
        if (s > (1 << N) - 1) s = (1 << N) - 1;
        return int'(s);
    endfunction

    always @(negedge clock_d) begin
        if (!reset_n) begin
            hs_q.delete();
        end else begin
            if (in_valid && in_ready) hs_q.push_back(edges + 1);
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done out=%0d want=no_done", out);
                end else begin
                    int e;
                    int h;
                    e = exp_q.pop_front();
                    h = (hs_q.size() != 0) ? hs_q.pop_front() : -1;
                    check("result", 32'(out), 32'(e));
                    check("latency", 32'(edges - h), 32'(L));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock_d);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        exp_q.delete();
        for (int k = 0; k < TAPS; k++) begin
            xm[k] = 0;
            cm[k] = 0;
        end
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wcoef(input int a, input int d, input bit upd);
        coef_addr = a[AB-1:0];
        coef_data = d[N-1:0];
        coef_we   = 1'b1;
        tick();
        coef_we = 1'b0;
        if (upd && a < TAPS) cm[a] = d;
    endtask

    task automatic push(input int val, input bit keep, input int want,
                        input bit cw = 0, input int ca = 0, input int cd = 0);
        int n = 0;
        in       = val[N-1:0];
        in_valid = 1'b1;
        if (cw) begin
            coef_addr = ca[AB-1:0];
            coef_data = cd[N-1:0];
            coef_we   = 1'b1;
        end
        @(negedge clock_d);
        while (!in_ready && n < L + 100) begin
            @(negedge clock_d);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout in_ready=%0d want=1", in_ready);
        end else begin
            last_hs = edges + 1;
            if (cw && ca < TAPS) cm[ca] = cd;
            for (int k = TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
            xm[0] = val;
            exp_q.push_back(want >= 0 ? want : model());
        end
        @(posedge clock_d);
        #1;
        coef_we = 1'b0;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock_d);
        while (!in_ready && n < L + 100) begin
            @(negedge clock_d);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL run_timeout in_ready=%0d want=1", in_ready);
        end
        tick();
    endtask

    initial begin
        int h1;
        do_reset();
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_out", 32'(out), 32'd0);
        push(4095, 0, 0);
        wait_idle();

        do_reset();
        wcoef(0, 4095, 1);
        push(4095, 0, 127);
        wait_idle();

        do_reset();
        wcoef(0, 2048, 1);
        push(2048, 0, 32);
        wait_idle();

        do_reset();
        wcoef(1, 4095, 1);
        push(4095, 1, 0);
        h1 = last_hs;
        push(0, 0, 127);
        check("hs_period", 32'(last_hs - h1), 32'(L + 1));
        wait_idle();

        do_reset();
        wcoef(0, 2048, 1);
        push(2048, 0, 32);
        repeat (100) tick();
        wcoef(0, 0, 0);
        wait_idle();
        wcoef(0, 0, 1);
        push(2048, 0, 0);
        wait_idle();

        do_reset();
        wcoef(0, 4095, 1);
        push(4095, 0, 127);
        repeat (999) tick();
        do_reset();
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        repeat (20) tick();
        wcoef(0, 4095, 1);
        push(4095, 0, 127);
        wait_idle();

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 3; j++) begin
                wcoef($urandom_range(0, 31), $urandom_range(0, 4095), 1);
            end
            push($urandom_range(0, 4095), 0, -1, 1,
                 $urandom_range(0, TAPS - 1), $urandom_range(0, 4095));
            wait_idle();
        end

        repeat (5) tick();
        check("pending", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
